// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Multiply is shift-add and divide is restoring, both on operand magnitudes,
// one iteration per cycle; signs are applied in a single fix-up cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_raw;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   prod;
    logic [CW-1:0]        count;
    logic                 sign_a;
    logic                 sign_b;
    logic                 b_zero;

    logic                 in_signed;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH+1:0]     div_trial;
    logic [2*WIDTH-1:0]   iter_next;
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;
    logic                 fix_dz;

    assign busy = (state != IDLE);

    // Operand magnitudes for the accept edge; op[0]=0 selects the signed variants.
    always_comb begin
        in_signed = ~op[0];
        a_abs     = (in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_abs     = (in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // One iteration of either algorithm. prod holds {upper, lower} halves:
    // multiply keeps {partial sum, remaining multiplier bits}, divide keeps
    // {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
        div_trial = {1'b0, prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]} - {2'b00, b_mag};
        if (op_q[1]) begin
            if (div_trial[WIDTH+1])
                iter_next = {prod[2*WIDTH-2:0], 1'b0};
            else
                iter_next = {div_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
        end else begin
            iter_next = {mul_sum, prod[WIDTH-1:1]};
        end
    end

    // Sign fix-up and special cases for the final HI/LO values.
    always_comb begin
        prod_neg = ~prod + 1'b1;
        fix_dz   = 1'b0;
        fix_hi   = prod[2*WIDTH-1:WIDTH];
        fix_lo   = prod[WIDTH-1:0];
        if (!op_q[1]) begin
            if (sign_a ^ sign_b) begin
                fix_hi = prod_neg[2*WIDTH-1:WIDTH];
                fix_lo = prod_neg[WIDTH-1:0];
            end
        end else if (b_zero) begin
            fix_dz = 1'b1;
            fix_hi = a_raw;
            fix_lo = {WIDTH{1'b1}};
        end else begin
            if (sign_a ^ sign_b)
                fix_lo = ~prod[WIDTH-1:0] + 1'b1;
            if (sign_a)
                fix_hi = ~prod[2*WIDTH-1:WIDTH] + 1'b1;
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op_q   <= 2'b00;
            a_raw  <= '0;
            b_mag  <= '0;
            prod   <= '0;
            count  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            done   <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        a_raw  <= a;
                        b_mag  <= b_abs;
                        prod   <= {{WIDTH{1'b0}}, a_abs};
                        sign_a <= in_signed & a[WIDTH-1];
                        sign_b <= in_signed & b[WIDTH-1];
                        b_zero <= (b == '0);
                        count  <= '0;
                        state  <= RUN;
                    end else begin
                        if (we_hi)
                            hi <= wdata;
                        if (we_lo)
                            lo <= wdata;
                    end
                end
                RUN: begin
                    prod  <= iter_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    dz    <= fix_dz;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit at WIDTH=32: a table of hand-computed
// vectors run back-to-back, plus sequences for busy/reset/direct-write cases.
module tb_mul_div_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             we_hi;
    logic             we_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    vec_t vecs [14];

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Called at a falling edge; presents a start request for the next rising edge.
    task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts rising edges until done is seen, then checks latency and results.
    task automatic wait_done(input string name, input int exp_lat, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input logic exp_dz);
        int cyc;
        cyc = 1;
        @(posedge clk);
        @(negedge clk);
        while (!done && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check_output({name, " latency"}, 64'(cyc), 64'(exp_lat));
        check_output({name, " hi"}, 64'(hi), 64'(exp_hi));
        check_output({name, " lo"}, 64'(lo), 64'(exp_lo));
        check_output({name, " dz"}, 64'(dz), 64'(exp_dz));
        check_output({name, " busy at done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int done_count;
        int cyc;

        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vecs[4]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[7]  = '{2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 1'b0};
        vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[11] = '{2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0};
        vecs[12] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[13] = '{2'b10, 32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000, 1'b0};

        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        we_hi = 1'b0;
        we_lo = 1'b0;
        wdata = '0;

        #2;
        check_output("reset busy", 64'(busy), 64'd0);
        check_output("reset done", 64'(done), 64'd0);
        check_output("reset dz", 64'(dz), 64'd0);
        check_output("reset hi", 64'(hi), 64'd0);
        check_output("reset lo", 64'(lo), 64'd0);

        // Release reset and start on the very first rising edge; later vectors
        // start in the done cycle of the previous one.
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            check_output($sformatf("vec%0d busy", i), 64'(busy), 64'd1);
            wait_done($sformatf("vec%0d", i), LAT, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz);
        end

        // Start request mid-operation with operands toggling: ignored, not queued.
        apply_stimulus(2'b01, 32'h00001234, 32'h00000010);
        cyc = 1;
        done_count = 0;
        a = 32'h0F0F0F0F;
        b = 32'hF0F0F0F0;
        @(posedge clk);
        @(negedge clk);
        while (!done && cyc < 100) begin
            cyc++;
            start = (cyc == 5);
            op    = 2'b00;
            a     = ~a;
            b     = ~b;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        check_output("busy-start latency", 64'(cyc), 64'(LAT));
        check_output("busy-start hi", 64'(hi), 64'h0);
        check_output("busy-start lo", 64'(lo), 64'h00012340);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy)
                done_count++;
        end
        check_output("busy-start extra activity", 64'(done_count), 64'd0);

        // Asynchronous reset between edges in the middle of a divide.
        apply_stimulus(2'b10, 32'h00000064, 32'h00000007);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2;
        reset = 1'b0;
        #1;
        check_output("mid-reset busy", 64'(busy), 64'd0);
        check_output("mid-reset hi", 64'(hi), 64'd0);
        check_output("mid-reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done)
                done_count++;
        end
        check_output("mid-reset no done", 64'(done_count), 64'd0);
        check_output("mid-reset lo held", 64'(lo), 64'd0);
        apply_stimulus(2'b01, 32'h00000003, 32'h00000004);
        wait_done("post-reset multu", LAT, 32'h0, 32'h0000000C, 1'b0);

        // Direct HI write in IDLE.
        we_hi = 1'b1;
        wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        we_hi = 1'b0;
        check_output("mthi hi", 64'(hi), 64'h12345678);
        check_output("mthi lo kept", 64'(lo), 64'h0000000C);
        check_output("mthi no done", 64'(done), 64'd0);

        // LO write together with an accepted start is dropped.
        we_lo = 1'b1;
        wdata = 32'hDEADBEEF;
        apply_stimulus(2'b01, 32'h00000002, 32'h00000003);
        we_lo = 1'b0;
        check_output("mtlo+start lo", 64'(lo), 64'h0000000C);
        check_output("mtlo+start busy", 64'(busy), 64'd1);

        // HI write while busy is ignored.
        we_hi = 1'b1;
        wdata = 32'hAAAAAAAA;
        @(posedge clk);
        @(negedge clk);
        we_hi = 1'b0;
        check_output("mthi busy hi", 64'(hi), 64'h12345678);
        wait_done("mtlo+start op", LAT - 1, 32'h0, 32'h00000006, 1'b0);

        // Both direct writes in the same IDLE cycle.
        we_hi = 1'b1;
        we_lo = 1'b1;
        wdata = 32'h55AA33CC;
        @(posedge clk);
        @(negedge clk);
        we_hi = 1'b0;
        we_lo = 1'b0;
        check_output("mthi+mtlo hi", 64'(hi), 64'h55AA33CC);
        check_output("mthi+mtlo lo", 64'(lo), 64'h55AA33CC);
        check_output("mthi+mtlo done", 64'(done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
